// File: rtl/unit_bus_port_if.sv
// Signal bundle between the Argon master bus, unit_bus_port and its attached unit.
// The slave modport is the port block's view; master is the surrounding environment.
interface unit_bus_port_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int CMD_WIDTH   = 4,
    parameter int WFIFO_DEPTH = 4
);
    localparam int COUNT_WIDTH = $clog2(WFIFO_DEPTH + 1);

    logic                   m_wvalid;
    logic [3:0]             m_write_id;
    logic [CMD_WIDTH-1:0]   m_write_cmd;
    logic [DATA_WIDTH-1:0]  m_wdata;
    logic                   m_wready;

    logic                   m_rreq;
    logic [3:0]             m_read_id;
    logic [CMD_WIDTH-1:0]   m_read_cmd;
    logic                   m_rready;
    logic                   m_rvalid;
    logic [DATA_WIDTH-1:0]  m_rdata;
    logic                   m_rerr;
    logic                   m_rack;

    logic                   u_valid;
    logic [CMD_WIDTH-1:0]   u_command;
    logic [DATA_WIDTH-1:0]  u_data;
    logic                   u_ready;
    logic                   u_rreq;
    logic [CMD_WIDTH-1:0]   u_read_cmd;
    logic                   u_rvalid;
    logic [DATA_WIDTH-1:0]  u_rdata;

    logic [COUNT_WIDTH-1:0] wcount;

    modport slave (
        input  m_wvalid, m_write_id, m_write_cmd, m_wdata,
        output m_wready,
        input  m_rreq, m_read_id, m_read_cmd, m_rack,
        output m_rready, m_rvalid, m_rdata, m_rerr,
        output u_valid, u_command, u_data, u_rreq, u_read_cmd,
        input  u_ready, u_rvalid, u_rdata,
        output wcount
    );

    modport master (
        output m_wvalid, m_write_id, m_write_cmd, m_wdata,
        input  m_wready,
        output m_rreq, m_read_id, m_read_cmd, m_rack,
        input  m_rready, m_rvalid, m_rdata, m_rerr,
        input  u_valid, u_command, u_data, u_rreq, u_read_cmd,
        output u_ready, u_rvalid, u_rdata,
        input  wcount
    );
endinterface

// File: rtl/unit_bus_port.sv
// Registered bus port for one unit: ID-decoded write FIFO toward the unit and a
// timed request/response read sequencer that only starts once all writes have drained.
module unit_bus_port #(
    parameter logic [3:0] UNIT_ID      = 4'h1,
    parameter int         DATA_WIDTH   = 16,
    parameter int         CMD_WIDTH    = 4,
    parameter int         WFIFO_DEPTH  = 4,
    parameter int         READ_TIMEOUT = 15
) (
    input logic            i_clk,
    input logic            i_reset,
    unit_bus_port_if.slave bus
);
    localparam int AW = $clog2(WFIFO_DEPTH);
    localparam int CW = $clog2(WFIFO_DEPTH + 1);
    localparam int TW = $clog2(READ_TIMEOUT + 1);
    localparam logic [CW-1:0] DEPTH_COUNT = CW'(WFIFO_DEPTH);
    localparam logic [TW-1:0] TIMER_LAST  = TW'(READ_TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [CMD_WIDTH-1:0]  cmd_mem  [WFIFO_DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [WFIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;

    logic [1:0]            state;
    logic [TW-1:0]         timer;
    logic                  rvalid;
    logic                  rerr;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  u_rreq;
    logic [CMD_WIDTH-1:0]  read_cmd;

    logic                  fifo_empty;
    logic                  fifo_not_full;
    logic                  read_ready;
    logic                  push;
    logic                  pop;
    logic                  read_accept;

    assign fifo_empty    = (count == '0);
    assign fifo_not_full = (count < DEPTH_COUNT);
    assign read_ready    = (state == ST_IDLE) && fifo_empty;

    // A full FIFO refuses the push even when the head leaves in the same cycle.
    assign push        = bus.m_wvalid && (bus.m_write_id == UNIT_ID) && fifo_not_full;
    assign pop         = !fifo_empty && bus.u_ready;
    assign read_accept = bus.m_rreq && (bus.m_read_id == UNIT_ID) && read_ready;

    assign bus.m_wready   = fifo_not_full;
    assign bus.u_valid    = !fifo_empty;
    assign bus.u_command  = cmd_mem[rd_ptr];
    assign bus.u_data     = data_mem[rd_ptr];
    assign bus.wcount     = count;
    assign bus.m_rready   = read_ready;
    assign bus.m_rvalid   = rvalid;
    assign bus.m_rerr     = rerr;
    assign bus.m_rdata    = rdata;
    assign bus.u_rreq     = u_rreq;
    assign bus.u_read_cmd = read_cmd;

    // Storage needs no reset: contents are only visible through u_valid.
    always_ff @(posedge i_clk) begin
        if (push) begin
            cmd_mem[wr_ptr]  <= bus.m_write_cmd;
            data_mem[wr_ptr] <= bus.m_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Read sequencer; a unit response on the timeout cycle takes priority over the error.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= ST_IDLE;
            timer    <= '0;
            rvalid   <= 1'b0;
            rerr     <= 1'b0;
            rdata    <= '0;
            u_rreq   <= 1'b0;
            read_cmd <= '0;
        end else begin
            u_rreq <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (read_accept) begin
                        read_cmd <= bus.m_read_cmd;
                        u_rreq   <= 1'b1;
                        timer    <= '0;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.u_rvalid) begin
                        rdata  <= bus.u_rdata;
                        rvalid <= 1'b1;
                        rerr   <= 1'b0;
                        state  <= ST_HOLD;
                    end else if (timer == TIMER_LAST) begin
                        rdata  <= '0;
                        rvalid <= 1'b1;
                        rerr   <= 1'b1;
                        state  <= ST_HOLD;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                ST_HOLD: begin
                    if (bus.m_rack) begin
                        rvalid <= 1'b0;
                        rerr   <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
